// File: rtl/v_tile_writer_if.sv
// v_tile_writer bus bundle: upstream valid/ready vector input plus the
// tile-side write port (write_en / write_rdy / w_data / write_ack).
// The "master" view belongs to the writer, which initiates tile writes.
interface v_tile_writer_if #(
    parameter int width      = 16,
    parameter int num_inputs = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_data [num_inputs-1:0];
    logic             write_en;
    logic             write_rdy;
    logic             write_ack;
    logic [width-1:0] w_data_out [num_inputs-1:0];

    // Writer side: consumes upstream vectors and drives the tile port.
    modport master (
        input  in_valid, in_data, write_rdy, write_ack,
        output in_ready, write_en, w_data_out
    );

    // Environment side: upstream source plus tile.
    modport slave (
        output in_valid, in_data, write_rdy, write_ack,
        input  in_ready, write_en, w_data_out
    );
endinterface

// File: rtl/v_tile_writer.sv
// v_tile_writer: buffers upstream vectors in a small FIFO and writes each one
// into a v_tile input port using the ready/enable/ack handshake. Counts
// completed writes and raises a sticky error when a tile fails to ack in time.
module v_tile_writer #(
    parameter int width          = 16,
    parameter int num_inputs     = 4,
    parameter int depth          = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    v_tile_writer_if.master        bus,
    output logic                   busy,
    output logic [15:0]            done_count,
    output logic                   timeout_err
);
    localparam int aw = $clog2(depth);
    localparam int cw = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam int unsigned to_last_i = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;

    typedef logic [aw:0]   ptr_t;
    typedef logic [cw-1:0] cnt_t;
    typedef enum logic { IDLE, DRIVE } state_t;

    localparam cnt_t to_last = cnt_t'(to_last_i);

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [width-1:0] fifo_mem [depth-1:0][num_inputs-1:0];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;

    // Write-port state
    state_t           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [width-1:0] w_data_q [num_inputs-1:0];
    logic [width-1:0] w_data_d [num_inputs-1:0];
    logic [15:0]      done_count_q, done_count_d;
    logic             timeout_err_q, timeout_err_d;

    logic full, empty, push, pop;

    // FIFO status and push decision
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
        push  = bus.in_valid && !full;
    end

    // Next-state logic for the write FSM, counters and output data
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        w_data_d      = w_data_q;
        done_count_d  = done_count_q;
        timeout_err_d = timeout_err_q;
        pop           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty && bus.write_rdy) begin
                    state_d  = DRIVE;
                    w_data_d = fifo_mem[rd_ptr_q[aw-1:0]];
                    cnt_d    = '0;
                end
            end
            DRIVE: begin
                // write_rdy is deliberately ignored here: once started, a
                // write runs until ack or timeout.
                if (bus.write_ack) begin
                    pop          = 1'b1;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = IDLE;
                end else if (timeout_cycles != 0 && cnt_q == to_last) begin
                    // Leave the entry at the head so it is retried.
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + ptr_t'(push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    end

    // Control registers with synchronous reset; reset aborts any write
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            done_count_q  <= '0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < num_inputs; i++) w_data_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            done_count_q  <= done_count_d;
            timeout_err_q <= timeout_err_d;
            w_data_q      <= w_data_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; pointer reset alone makes stale contents unreachable.
        if (push && !reset) fifo_mem[wr_ptr_q[aw-1:0]] <= bus.in_data;
    end

    assign bus.in_ready   = !full;
    assign bus.write_en   = (state_q == DRIVE);
    assign bus.w_data_out = w_data_q;
    assign busy           = !empty || (state_q != IDLE);
    assign done_count     = done_count_q;
    assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_v_tile_writer.sv
// Testbench for v_tile_writer: directed stimulus, a tile model that acks after
// a programmable delay, and a scoreboard monitor that checks each completed
// write against the queue of vectors pushed upstream.
module tb_v_tile_writer;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] done_count;
    logic        timeout_err;

    v_tile_writer_if #(.width(W), .num_inputs(N)) bus ();

    v_tile_writer #(.width(W), .num_inputs(N), .depth(4), .timeout_cycles(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .done_count  (done_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    // Tile model controls
    logic ack_en    = 1'b0;
    int   ack_delay = 0;
    logic model_ack = 1'b0;
    logic stray     = 1'b0;
    assign bus.write_ack = model_ack | stray;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [W-1:0] v [N-1:0]);
        logic [63:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = v[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector and wait (bounded) until it is accepted.
    task automatic push_vec(input logic [63:0] v);
        int i;
        for (int k = 0; k < N; k++) bus.in_data[k] = v[k*W +: W];
        bus.in_valid = 1'b1;
        for (i = 0; i < 200 && bus.in_ready !== 1'b1; i++) tick();
        check("push_accept", {63'd0, bus.in_ready}, 64'd1);
        exp_q.push_back(v);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_en(input logic lvl);
        int i;
        for (i = 0; i < 200 && bus.write_en !== lvl; i++) tick();
        check("wait_write_en", {63'd0, bus.write_en}, {63'd0, lvl});
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400 && busy !== 1'b0; i++) tick();
        check("wait_idle", {63'd0, busy}, 64'd0);
    endtask

    // Count consecutive cycles write_en is sampled high.
    task automatic measure_high(output int n);
        n = 0;
        while (bus.write_en === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Tile model: acks once write_en has been high for more than ack_delay cycles
    initial begin
        int hi = 0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.write_en === 1'b1) hi++;
            else hi = 0;
            model_ack = ack_en && (bus.write_en === 1'b1) && (hi > ack_delay);
        end
    end

    // Scoreboard monitor: data stability, in-order completion, gap after each write
    initial begin
        logic        was_en    = 1'b0;
        logic        prev_done = 1'b0;
        logic [63:0] cap       = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                was_en    = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("gap_after_write", {63'd0, bus.write_en}, 64'd0);
                if (bus.write_en === 1'b1) begin
                    if (!was_en) cap = pack(bus.w_data_out);
                    else check("w_data_stable", pack(bus.w_data_out), cap);
                end
                if (bus.write_en === 1'b1 && bus.write_ack === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0h expected none", pack(bus.w_data_out));
                    end else begin
                        check("write_data", pack(bus.w_data_out), exp_q.pop_front());
                    end
                    prev_done = 1'b1;
                end else begin
                    prev_done = 1'b0;
                end
                was_en = bus.write_en;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.write_rdy = 1'b0;
        for (int k = 0; k < N; k++) bus.in_data[k] = '0;
        tick();
        tick();
        // Reset state
        check("rst_write_en", {63'd0, bus.write_en}, 64'd0);
        check("rst_w_data", pack(bus.w_data_out), 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {48'd0, done_count}, 64'd0);
        check("rst_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b0;

        // 1. Single write, ack two cycles after write_en rises
        bus.write_rdy = 1'b1;
        ack_en = 1'b1;
        ack_delay = 2;
        push_vec(64'h0004_0003_0002_0001);
        check("t1_latency_e0", {63'd0, bus.write_en}, 64'd0);
        tick();
        check("t1_latency_e1", {63'd0, bus.write_en}, 64'd1);
        check("t1_w_data", pack(bus.w_data_out), 64'h0004_0003_0002_0001);
        measure_high(n);
        check("t1_high_cycles", 64'(n), 64'd3);
        check("t1_busy", {63'd0, busy}, 64'd0);
        check("t1_done", {48'd0, done_count}, 64'd1);

        // 2. Fill while tile is stalled, then drain with immediate ack
        do_reset();
        bus.write_rdy = 1'b0;
        ack_delay = 0;
        push_vec(64'h0011_0012_0013_0014);
        push_vec(64'h0021_0022_0023_0024);
        push_vec(64'h0031_0032_0033_0034);
        push_vec(64'h0041_0042_0043_0044);
        check("t2_full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int k = 0; k < N; k++) bus.in_data[k] = 16'h0050 + 16'(k);
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("t2_held_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("t2_no_write", {63'd0, bus.write_en}, 64'd0);
        bus.write_rdy = 1'b1;
        push_vec(64'h0053_0052_0051_0050);
        wait_idle();
        check("t2_done", {48'd0, done_count}, 64'd5);
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // 3. Ready gating
        do_reset();
        bus.write_rdy = 1'b0;
        push_vec(64'hAAAA_BBBB_CCCC_DDDD);
        for (int c = 0; c < 10; c++) begin
            check("t3_gated", {63'd0, bus.write_en}, 64'd0);
            tick();
        end
        bus.write_rdy = 1'b1;
        tick();
        check("t3_rise", {63'd0, bus.write_en}, 64'd1);
        wait_idle();
        check("t3_done", {48'd0, done_count}, 64'd1);

        // 4. Timeout then successful retry
        do_reset();
        ack_en = 1'b0;
        push_vec(64'h1234_5678_9ABC_DEF0);
        wait_en(1'b1);
        measure_high(n);
        check("t4_high_cycles", 64'(n), 64'(TO));
        check("t4_timeout_err", {63'd0, timeout_err}, 64'd1);
        check("t4_not_popped", {63'd0, busy}, 64'd1);
        ack_en = 1'b1;
        wait_en(1'b1);
        wait_idle();
        check("t4_done", {48'd0, done_count}, 64'd1);
        check("t4_empty", {63'd0, bus.in_ready}, 64'd1);
        check("t4_err_sticky", {63'd0, timeout_err}, 64'd1);

        // 5. Reset in the middle of a write (timeout_err still set from above)
        ack_en = 1'b0;
        push_vec(64'h0001_0001_0001_0001);
        push_vec(64'h0002_0002_0002_0002);
        push_vec(64'h0003_0003_0003_0003);
        wait_en(1'b1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("t5_write_en", {63'd0, bus.write_en}, 64'd0);
        check("t5_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("t5_done", {48'd0, done_count}, 64'd0);
        check("t5_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b0;
        stray = 1'b1;
        tick();
        tick();
        stray = 1'b0;
        check("t5_late_ack_done", {48'd0, done_count}, 64'd0);
        check("t5_late_ack_busy", {63'd0, busy}, 64'd0);

        // 6. Stray ack with an entry waiting, then done_count wrap
        bus.write_rdy = 1'b0;
        push_vec(64'hFEED_BEEF_CAFE_F00D);
        stray = 1'b1;
        tick();
        tick();
        stray = 1'b0;
        check("t6_stray_done", {48'd0, done_count}, 64'd0);
        check("t6_stray_no_pop", {63'd0, busy}, 64'd1);
        force dut.done_count_q = 16'hFFFF;
        tick();
        release dut.done_count_q;
        tick();
        check("t6_preload", {48'd0, done_count}, 64'h0000_0000_0000_FFFF);
        ack_en = 1'b1;
        ack_delay = 1;
        bus.write_rdy = 1'b1;
        wait_en(1'b1);
        wait_idle();
        check("t6_wrap", {48'd0, done_count}, 64'd0);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/v_tile_writer.md
Name: v_tile_writer

Overview:
- Initiator side of the v_tile vector write port (write_en / write_rdy / w_data / write_ack).
- Buffers vectors from an upstream valid/ready source in a small FIFO.
- Drives each vector into one tile input port (port 1 or 2) using the tile's ready/enable/ack handshake.
- Counts completed writes and flags tiles that never acknowledge.

Parameters:
- width, 16, bits per vector element
- num_inputs, 4, elements per vector
- depth, 4, FIFO entries (power of two, >=2)
- timeout_cycles, 64, max cycles write_en may stay high without write_ack; 0 disables the timeout

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream vector valid
- in_ready  out  1  FIFO can accept; equals !full (combinational)
- in_data  in  width x num_inputs  upstream vector (unpacked array [num_inputs-1:0])
- write_en  out  1  to tile write_enN
- write_rdy  in  1  from tile write_rdyN
- w_data_out  out  width x num_inputs  to tile w_data_inN
- write_ack  in  1  from tile write_ackN
- busy  out  1  FIFO non-empty or state != IDLE
- done_count  out  16  completed writes; wraps 0xFFFF->0
- timeout_err  out  1  sticky; set on ack timeout

Behaviour:
- Reset:
  - write_en=0, w_data_out=0, FIFO empty (in_ready=1), busy=0, done_count=0, timeout_err=0, state=IDLE, timeout counter=0.
  - Reset mid-transfer aborts the write: write_en is low after the reset edge and the FIFO is flushed.
- FIFO:
  - Push on an edge with in_valid && in_ready.
  - Pop only on a completed write (see DRIVE below).
  - Push and pop on the same edge: both occur, occupancy unchanged.
  - When full, in_ready=0 and in_valid is ignored; there is no push-through.
- FSM (registered; write_en = (state==DRIVE)):
  - IDLE:
    - If FIFO non-empty and write_rdy=1 at an edge: go to DRIVE, load w_data_out from the FIFO head, clear the timeout counter.
    - Otherwise stay in IDLE.
  - DRIVE:
    - w_data_out is held stable.
    - If write_ack=1 at an edge: pop the head, done_count+=1, go to IDLE.
    - Else if timeout_cycles!=0 and the counter reaches timeout_cycles-1: set timeout_err, go to IDLE without popping. The same entry is retried.
    - Else increment the counter.
  - write_rdy dropping while in DRIVE does not abort the write; the block keeps driving until ack or timeout.
- Timing:
  - Latency: a vector pushed at edge E0 into an empty FIFO, with write_rdy already high, gives write_en=1 after edge E1.
  - write_en falls after the edge that samples write_ack.
  - write_en is low for at least one cycle between consecutive writes. Minimum per-vector period is 2 cycles with ack in the first DRIVE cycle.
- write_ack while in IDLE is ignored: no pop, no count.
- w_data_out keeps its last value in IDLE and is only updated on IDLE->DRIVE.
- busy is 0 only when the FIFO is empty and state=IDLE.
- timeout_err clears only on reset.

Test Plan:
1. Single write:
   - Stimulus: push {0004,0003,0002,0001} (elements [3:0]); write_rdy=1; tile model acks 2 cycles after write_en rises.
   - Required: write_en high exactly 3 cycles; w_data_out equals the pushed vector throughout; done_count=1; busy=0 one cycle after write_en falls.
2. Back-to-back and full:
   - Stimulus: push 5 vectors on consecutive cycles with the tile stalled (write_rdy=0).
   - Required: in_ready=0 after the 4th push; the 5th is held by the source. Release write_rdy with immediate ack: the 5 vectors emerge in order, with write_en low for at least 1 cycle between each; done_count=5.
3. Ready gating:
   - Stimulus: FIFO holds 1 vector, write_rdy=0 for 10 cycles, then 1.
   - Required: write_en stays 0 for those 10 cycles and rises on the edge after write_rdy=1.
4. Timeout and retry:
   - Stimulus: timeout_cycles=8; tile never acks the first attempt.
   - Required: write_en drops after exactly 8 high cycles; timeout_err=1; the entry is retried. Ack the retry: done_count=1, FIFO empty, timeout_err still 1.
5. Reset mid-write:
   - Stimulus: 3 vectors queued, reset asserted while write_en=1.
   - Required: after the reset edge write_en=0, in_ready=1, done_count=0, timeout_err=0; a later write_ack is ignored.
6. Stray ack and wrap:
   - Stimulus: pulse write_ack in IDLE.
   - Required: no count change.
   - Stimulus: force 0xFFFF completions (or preload via backdoor).
   - Required: the next write wraps done_count to 0.
